// File: rtl/urv_exceptions_if.sv
// X-stage trap/CSR bus between the pipeline and urv_exceptions.
// master: the pipeline side that drives the X-stage inputs.
// slave:  the trap controller that consumes them and drives redirect and CSRs.
interface urv_exceptions_if;
    logic        x_stall_i;
    logic        x_kill_i;
    logic        x_valid_i;
    logic        d_is_csr_i;
    logic [11:0] d_csr_sel_i;
    logic [31:0] x_csr_write_value_i;
    logic        d_is_mret_i;
    logic        x_exception_i;
    logic [3:0]  x_exception_cause_i;
    logic [31:0] x_exception_pc_i;
    logic        irq_i;
    logic        timer_tick_i;
    logic        x_exception_o;
    logic [31:0] x_exception_pc_o;
    logic [31:0] csr_mstatus_o;
    logic [31:0] csr_mip_o;
    logic [31:0] csr_mie_o;
    logic [31:0] csr_mepc_o;
    logic [31:0] csr_mcause_o;

    modport master (
        output x_stall_i, x_kill_i, x_valid_i, d_is_csr_i, d_csr_sel_i,
               x_csr_write_value_i, d_is_mret_i, x_exception_i,
               x_exception_cause_i, x_exception_pc_i, irq_i, timer_tick_i,
        input  x_exception_o, x_exception_pc_o, csr_mstatus_o, csr_mip_o,
               csr_mie_o, csr_mepc_o, csr_mcause_o
    );

    modport slave (
        input  x_stall_i, x_kill_i, x_valid_i, d_is_csr_i, d_csr_sel_i,
               x_csr_write_value_i, d_is_mret_i, x_exception_i,
               x_exception_cause_i, x_exception_pc_i, irq_i, timer_tick_i,
        output x_exception_o, x_exception_pc_o, csr_mstatus_o, csr_mip_o,
               csr_mie_o, csr_mepc_o, csr_mcause_o
    );
endinterface

// File: rtl/urv_exceptions.sv
// Machine-mode trap/interrupt controller for the X stage.
// Owns mstatus/mie/mip/mepc/mcause, decides trap entry and MRET return,
// and supplies the fetch redirect target.
// Optional build macro: URV_TIMER_IRQ_EN enables the timer interrupt (MTIP/MTIE).
module urv_exceptions #(
    parameter logic [31:0] TRAP_VECTOR     = 32'h0000_0008,
    parameter int unsigned IRQ_SYNC_STAGES = 2
) (
    input logic            clk_i,
    input logic            rst_i,
    urv_exceptions_if.slave bus
);
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MIP     = 12'h344;

    logic [IRQ_SYNC_STAGES-1:0] irq_sync;
    logic        mstatus_mie;
    logic        mstatus_mpie;
    logic        mie_meie;
    logic        mie_mtie;
    logic        mip_mtip;
    logic        mip_meip;
    logic [31:0] mepc;
    logic [31:0] mcause;

    logic        advance;
    logic        pend_ext;
    logic        pend_tim;
    logic        irq_take;
    logic        do_trap;
    logic        do_mret;
    logic        do_csr;
    logic        csr_wr;
    logic [31:0] trap_cause;
    logic [31:0] wval;

    assign wval     = bus.x_csr_write_value_i;
    assign mip_meip = irq_sync[IRQ_SYNC_STAGES-1];

    // Event decode and trap priority: exception > interrupt > MRET > CSR write.
    always_comb begin
        advance    = bus.x_valid_i & ~bus.x_stall_i & ~bus.x_kill_i;
        pend_ext   = mip_meip & mie_meie;
        pend_tim   = mip_mtip & mie_mtie;
        irq_take   = mstatus_mie & (pend_ext | pend_tim);
        do_trap    = bus.x_exception_i | irq_take;
        do_mret    = ~do_trap & bus.d_is_mret_i;
        do_csr     = ~do_trap & ~bus.d_is_mret_i & bus.d_is_csr_i;
        csr_wr     = advance & do_csr;
        trap_cause = bus.x_exception_i ? {28'b0, bus.x_exception_cause_i}
                                       : {1'b1, 27'b0, (pend_ext ? 4'd11 : 4'd7)};
    end

    // Fetch redirect; forced idle while in reset.
    always_comb begin
        bus.x_exception_o    = ~rst_i & advance & (do_trap | do_mret);
        bus.x_exception_pc_o = TRAP_VECTOR;
        if (!rst_i && do_mret)
            bus.x_exception_pc_o = mepc;
    end

    // External interrupt synchronizer, runs every cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i)
            irq_sync <= '0;
        else
            irq_sync <= {irq_sync[IRQ_SYNC_STAGES-2:0], bus.irq_i};
    end

    // Architectural CSR updates on an advancing X instruction.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mstatus_mie  <= 1'b0;
            mstatus_mpie <= 1'b0;
            mie_meie     <= 1'b0;
            mepc         <= '0;
            mcause       <= '0;
        end else if (advance) begin
            if (do_trap) begin
                mepc         <= bus.x_exception_pc_i;
                mcause       <= trap_cause;
                mstatus_mpie <= mstatus_mie;
                mstatus_mie  <= 1'b0;
            end else if (do_mret) begin
                mstatus_mie  <= mstatus_mpie;
                mstatus_mpie <= 1'b1;
            end else if (do_csr) begin
                case (bus.d_csr_sel_i)
                    CSR_MSTATUS: begin
                        mstatus_mie  <= wval[3];
                        mstatus_mpie <= wval[7];
                    end
                    CSR_MIE:    mie_meie <= wval[11];
                    CSR_MEPC:   mepc     <= {wval[31:2], 2'b00};
                    CSR_MCAUSE: mcause   <= wval;
                    default: ;
                endcase
            end
        end
    end

`ifdef URV_TIMER_IRQ_EN
    // Timer enable, written only by a CSR write to mie.
    always_ff @(posedge clk_i) begin
        if (rst_i)
            mie_mtie <= 1'b0;
        else if (csr_wr && bus.d_csr_sel_i == CSR_MIE)
            mie_mtie <= wval[7];
    end

    // Sticky MTIP: a tick sets it every cycle and beats a same-edge clear.
    always_ff @(posedge clk_i) begin
        if (rst_i)
            mip_mtip <= 1'b0;
        else if (bus.timer_tick_i)
            mip_mtip <= 1'b1;
        else if (csr_wr && bus.d_csr_sel_i == CSR_MIP)
            mip_mtip <= wval[7];
    end
`else
    logic unused_timer;
    assign unused_timer = bus.timer_tick_i ^ csr_wr;
    assign mie_mtie     = 1'b0;
    assign mip_mtip     = 1'b0;
`endif

    // CSR read views for the CSR stage.
    always_comb begin
        bus.csr_mstatus_o = {24'b0, mstatus_mpie, 3'b0, mstatus_mie, 3'b0};
        bus.csr_mie_o     = {20'b0, mie_meie, 3'b0, mie_mtie, 7'b0};
        bus.csr_mip_o     = {20'b0, mip_meip, 3'b0, mip_mtip, 7'b0};
        bus.csr_mepc_o    = mepc;
        bus.csr_mcause_o  = mcause;
    end
endmodule

// File: tb/tb_urv_exceptions.sv
// Directed self-checking bench for urv_exceptions.
module tb_urv_exceptions;
    logic clk;
    logic rst;
    int   tests;
    int   fails;

    urv_exceptions_if bus ();

    urv_exceptions #(
        .TRAP_VECTOR     (32'h0000_0008),
        .IRQ_SYNC_STAGES (2)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.x_stall_i           = 1'b0;
        bus.x_kill_i            = 1'b0;
        bus.x_valid_i           = 1'b0;
        bus.d_is_csr_i          = 1'b0;
        bus.d_csr_sel_i         = 12'h000;
        bus.x_csr_write_value_i = 32'h0;
        bus.d_is_mret_i         = 1'b0;
        bus.x_exception_i       = 1'b0;
        bus.x_exception_cause_i = 4'h0;
        bus.x_exception_pc_i    = 32'h0;
        bus.timer_tick_i        = 1'b0;
    endtask

    task automatic csr_write(input logic [11:0] sel, input logic [31:0] val);
        bus.x_valid_i           = 1'b1;
        bus.d_is_csr_i          = 1'b1;
        bus.d_csr_sel_i         = sel;
        bus.x_csr_write_value_i = val;
        step();
        idle();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        idle();
        bus.irq_i = 1'b0;
        rst = 1'b1;

        // Reset: redirect idle even with a trap presented.
        bus.x_valid_i     = 1'b1;
        bus.x_exception_i = 1'b1;
        step();
        step();
        check("rst_exc_o", 32'(bus.x_exception_o), 32'h0);
        check("rst_pc_o", bus.x_exception_pc_o, 32'h8);
        idle();
        rst = 1'b0;
        #1;
        check("rst_mstatus", bus.csr_mstatus_o, 32'h0);
        check("rst_mie", bus.csr_mie_o, 32'h0);
        check("rst_mip", bus.csr_mip_o, 32'h0);
        check("rst_mepc", bus.csr_mepc_o, 32'h0);
        check("rst_mcause", bus.csr_mcause_o, 32'h0);

        // Synchronous exception.
        bus.x_valid_i           = 1'b1;
        bus.x_exception_i       = 1'b1;
        bus.x_exception_cause_i = 4'h2;
        bus.x_exception_pc_i    = 32'h100;
        #1;
        check("exc_o", 32'(bus.x_exception_o), 32'h1);
        check("exc_pc_o", bus.x_exception_pc_o, 32'h8);
        step();
        idle();
        check("exc_mepc", bus.csr_mepc_o, 32'h100);
        check("exc_mcause", bus.csr_mcause_o, 32'h2);
        check("exc_mstatus", bus.csr_mstatus_o, 32'h0);

        // CSR write masking.
        csr_write(12'h300, 32'hFFFF_FFFF);
        check("mstatus_mask", bus.csr_mstatus_o, 32'h88);
        csr_write(12'h300, 32'h8);
        check("mstatus_8", bus.csr_mstatus_o, 32'h8);
        csr_write(12'h341, 32'h103);
        check("mepc_mask", bus.csr_mepc_o, 32'h100);
        csr_write(12'h304, 32'hFFFF_FFFF);
`ifdef URV_TIMER_IRQ_EN
        check("mie_mask", bus.csr_mie_o, 32'h880);
`else
        check("mie_mask", bus.csr_mie_o, 32'h800);
`endif
        csr_write(12'h304, 32'h800);
        check("mie_800", bus.csr_mie_o, 32'h800);
        csr_write(12'h342, 32'h1234_5678);
        check("mcause_full", bus.csr_mcause_o, 32'h1234_5678);
        csr_write(12'h345, 32'hFFFF_FFFF);
        check("bad_addr_mcause", bus.csr_mcause_o, 32'h1234_5678);
        check("bad_addr_mepc", bus.csr_mepc_o, 32'h100);
        check("bad_addr_mstatus", bus.csr_mstatus_o, 32'h8);

        // External IRQ through the synchronizer.
        bus.irq_i = 1'b1;
        step();
        check("irq_sync1", bus.csr_mip_o, 32'h0);
        step();
        check("irq_sync2", bus.csr_mip_o, 32'h800);
        check("irq_novalid", 32'(bus.x_exception_o), 32'h0);

        // Stall hold: pending interrupt waits for the first unstalled cycle.
        bus.x_valid_i        = 1'b1;
        bus.x_stall_i        = 1'b1;
        bus.x_exception_pc_i = 32'h200;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_exc_o", 32'(bus.x_exception_o), 32'h0);
            step();
            check("stall_mepc", bus.csr_mepc_o, 32'h100);
        end
        bus.x_stall_i = 1'b0;
        #1;
        check("irq_exc_o", 32'(bus.x_exception_o), 32'h1);
        check("irq_pc_o", bus.x_exception_pc_o, 32'h8);
        step();
        idle();
        check("irq_mcause", bus.csr_mcause_o, 32'h8000_000B);
        check("irq_mstatus", bus.csr_mstatus_o, 32'h80);
        check("irq_mepc", bus.csr_mepc_o, 32'h200);

        // MRET returns to mepc and re-enables interrupts.
        bus.x_valid_i   = 1'b1;
        bus.d_is_mret_i = 1'b1;
        #1;
        check("mret_exc_o", 32'(bus.x_exception_o), 32'h1);
        check("mret_pc_o", bus.x_exception_pc_o, 32'h200);
        step();
        idle();
        check("mret_mstatus", bus.csr_mstatus_o, 32'h88);

        // Interrupt and MRET together: trap wins.
        bus.x_valid_i        = 1'b1;
        bus.d_is_mret_i      = 1'b1;
        bus.x_exception_pc_i = 32'h300;
        #1;
        check("prio_exc_o", 32'(bus.x_exception_o), 32'h1);
        check("prio_pc_o", bus.x_exception_pc_o, 32'h8);
        step();
        idle();
        check("prio_mstatus", bus.csr_mstatus_o, 32'h80);
        check("prio_mepc", bus.csr_mepc_o, 32'h300);
        bus.irq_i = 1'b0;
        step();
        step();
        step();
        check("irq_drop_mip", bus.csr_mip_o, 32'h0);

        // Exception suppresses the same instruction's CSR write.
        bus.x_valid_i           = 1'b1;
        bus.x_exception_i       = 1'b1;
        bus.x_exception_cause_i = 4'h5;
        bus.x_exception_pc_i    = 32'h400;
        bus.d_is_csr_i          = 1'b1;
        bus.d_csr_sel_i         = 12'h304;
        bus.x_csr_write_value_i = 32'h0;
        step();
        idle();
        check("supp_mie", bus.csr_mie_o, 32'h800);
        check("supp_mcause", bus.csr_mcause_o, 32'h5);
        check("supp_mepc", bus.csr_mepc_o, 32'h400);
        check("supp_mstatus", bus.csr_mstatus_o, 32'h0);

        // Killed instruction neither redirects nor updates state.
        bus.x_valid_i           = 1'b1;
        bus.x_kill_i            = 1'b1;
        bus.x_exception_i       = 1'b1;
        bus.x_exception_cause_i = 4'h3;
        bus.x_exception_pc_i    = 32'h500;
        #1;
        check("kill_exc_o", 32'(bus.x_exception_o), 32'h0);
        step();
        idle();
        check("kill_mepc", bus.csr_mepc_o, 32'h400);
        check("kill_mcause", bus.csr_mcause_o, 32'h5);

        // Timer tick and MTIP stickiness.
        bus.timer_tick_i = 1'b1;
        step();
        idle();
`ifdef URV_TIMER_IRQ_EN
        check("tick_mip", bus.csr_mip_o, 32'h80);
`else
        check("tick_mip", bus.csr_mip_o, 32'h0);
`endif
        bus.timer_tick_i = 1'b1;
        csr_write(12'h344, 32'h0);
`ifdef URV_TIMER_IRQ_EN
        check("tick_vs_clear", bus.csr_mip_o, 32'h80);
`else
        check("tick_vs_clear", bus.csr_mip_o, 32'h0);
`endif
        csr_write(12'h344, 32'h0);
        check("clear_mip", bus.csr_mip_o, 32'h0);
        csr_write(12'h344, 32'hFFFF_FFFF);
`ifdef URV_TIMER_IRQ_EN
        check("write_mip", bus.csr_mip_o, 32'h80);
`else
        check("write_mip", bus.csr_mip_o, 32'h0);
`endif

        // Reset in the middle of a trap discards everything.
        bus.x_valid_i        = 1'b1;
        bus.x_exception_i    = 1'b1;
        bus.x_exception_pc_i = 32'h600;
        rst = 1'b1;
        #1;
        check("midrst_exc_o", 32'(bus.x_exception_o), 32'h0);
        check("midrst_pc_o", bus.x_exception_pc_o, 32'h8);
        step();
        idle();
        rst = 1'b0;
        #1;
        check("midrst_mepc", bus.csr_mepc_o, 32'h0);
        check("midrst_mie", bus.csr_mie_o, 32'h0);
        check("midrst_mcause", bus.csr_mcause_o, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/urv_exceptions.md
Name: urv_exceptions

Overview:
- Trap/interrupt controller sitting directly upstream of the CSR read/modify stage.
- Owns mstatus, mie, mip, mepc and mcause; feeds them to the CSR stage as csr_*_o.
- Consumes that stage's write value (x_csr_write_value_i) to update its registers.
- Decides trap entry for synchronous exceptions and interrupts, and return on MRET, in the X stage; supplies the redirect PC to fetch.

Parameters:
- TRAP_VECTOR, 32'h00000008, PC loaded on any trap entry.
- IRQ_SYNC_STAGES, 2, flip-flop stages on irq_i (min 2).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- x_stall_i  in  1  X stage stalled; no state update this cycle
- x_kill_i  in  1  X instruction killed; no state update this cycle
- x_valid_i  in  1  X holds a valid instruction eligible to be interrupted
- d_is_csr_i  in  1  X instruction is a CSR op
- d_csr_sel_i  in  12  CSR address of that op
- x_csr_write_value_i  in  32  new CSR value from the CSR stage
- d_is_mret_i  in  1  X instruction is MRET
- x_exception_i  in  1  synchronous exception raised by X instruction
- x_exception_cause_i  in  4  cause code of that exception
- x_exception_pc_i  in  32  PC of X instruction
- irq_i  in  1  external interrupt, asynchronous level
- timer_tick_i  in  1  one-cycle timer-compare pulse
- x_exception_o  out  1  redirect fetch this cycle (trap or MRET)
- x_exception_pc_o  out  32  redirect target
- csr_mstatus_o, csr_mip_o, csr_mie_o, csr_mepc_o, csr_mcause_o  out  32 each  CSR values

Behaviour:
- Reset values: mstatus = 0 (MIE bit3 = 0, MPIE bit7 = 0), mie = 0, mip = 0, mepc = 0, mcause = 0, sync flops = 0.
- Reset mid-trap discards everything.
- x_exception_o = 0 and x_exception_pc_o = TRAP_VECTOR while rst_i is high.
- advance = x_valid_i & !x_stall_i & !x_kill_i. All register writes happen only on a clock edge where advance = 1, except the irq synchronizer and MTIP set, which run every cycle.
- irq_i passes through IRQ_SYNC_STAGES flops; the final stage drives mip[11] (MEIP) directly, read-only.
- Pending = mip & mie & {bits 11,7}; irq_take = mstatus[3] & |pending.
- Priority, combinational, same cycle:
  - x_exception_i: trap. mcause = {1'b0, 27'b0, cause}.
  - else irq_take: trap. mcause[31] = 1, code 11 if MEIP pending, else 7.
  - else d_is_mret_i: return.
  - else if d_is_csr_i: CSR write.
- Trap:
  - x_exception_o = advance; x_exception_pc_o = TRAP_VECTOR.
  - On the edge: mepc = x_exception_pc_i; mcause as above; MPIE = MIE; MIE = 0.
  - Any CSR write by the same instruction is suppressed.
  - Interrupt traps do not retire the X instruction; mepc points at it.
- MRET:
  - x_exception_o = advance; x_exception_pc_o = mepc.
  - On the edge: MIE = MPIE; MPIE = 1.
- CSR write (address 0x300/0x304/0x341/0x342/0x344):
  - mstatus: only bits 3 and 7 are writable.
  - mie: only bits 11 and 7 are writable.
  - mepc[1:0]: forced to 0.
  - mcause: full write.
  - mip: only bit 7 is writable.
  - Writes to other addresses are ignored.
- Simultaneous events:
  - timer_tick_i and a CSR write clearing bit 7 on the same edge: bit 7 ends set (tick wins).
  - irq_take and d_is_mret_i on the same cycle: trap wins, MRET is not executed.
- Stall: x_exception_o is held 0 while x_stall_i or x_kill_i is high; a pending interrupt remains pending.
- Latency: irq_i to mip[11] visible takes IRQ_SYNC_STAGES cycles. Trap redirect is combinational in the cycle X advances.

Optional Feature:
- Macro URV_TIMER_IRQ_EN.
- Defined: timer_tick_i sets mip[7] (MTIP, sticky) every cycle, independent of advance. MTIP is cleared only by a CSR write with bit 7 = 0. mie[7] is writable.
- Undefined: mip[7] and mie[7] read 0 and are not writable; timer_tick_i is ignored; only external and synchronous traps exist.

Test Plan:
- Reset: rst_i = 1 for 2 cycles -> all csr_*_o = 0, x_exception_o = 0.
- Synchronous exception: x_exception_i = 1, cause = 4'h2, pc = 32'h100, advance = 1 -> x_exception_o = 1, pc_o = 32'h8. Next cycle: mepc = 32'h100, mcause = 32'h2, mstatus = 0.
- External IRQ:
  - Setup: set mstatus = 32'h8, mie = 32'h800.
  - Stimulus: raise irq_i.
  - Response: mip[11] = 1 after 2 cycles; trap taken on first advance; mcause = 32'h8000000B; mstatus = 32'h80.
  - Follow-up: MRET -> pc_o = mepc, mstatus returns to 32'h88.
- Stall hold: irq pending with x_stall_i = 1 for 3 cycles -> x_exception_o = 0 throughout, mepc unchanged; trap fires on the first unstalled cycle.
- Timer, URV_TIMER_IRQ_EN defined:
  - Tick pulse -> mip = 32'h80.
  - CSR write mip = 0 on the same edge as a tick -> mip stays 32'h80.
  - Write alone -> mip = 0.
  - Macro undefined -> mip stays 0.
- CSR masking: write mstatus = 32'hFFFFFFFF -> reads 32'h88; write mepc = 32'h103 -> reads 32'h100.
